// File: rtl/sequenciador_ciclo.sv
// Multi-cycle instruction sequencer for the 8-bit core: steps fetch/decode/execute/memory/write-back
// and drives the per-cycle datapath enables, memory handshake and retired-instruction counter.
module sequenciador_ciclo (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] OPcode,
    input  logic [1:0] BitVerificao,
    input  logic       Zero,
    input  logic       MemPronto,
    output logic       MemReq,
    output logic       MemEscrita,
    output logic       EndSel,
    output logic       CarregaIR,
    output logic       EscrevePC,
    output logic [1:0] FontePC,
    output logic       HabEscritaReg,
    output logic [2:0] Estado,
    output logic       Parado,
    output logic [7:0] Instrucoes
);

    localparam int unsigned OP_W  = 3;
    localparam int unsigned BV_W  = 2;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] PC_MAIS1  = 2'b00;
    localparam logic [1:0] PC_DESVIO = 2'b01;
    localparam logic [1:0] PC_SALTO  = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    typedef enum logic [2:0] {
        BUSCA      = 3'b000,
        DECODIFICA = 3'b001,
        EXECUTA    = 3'b010,
        MEMORIA    = 3'b011,
        ESCRITA    = 3'b100,
        PARADO     = 3'b101
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [OP_W-1:0]    opcode_q, opcode_d;
    logic [BV_W-1:0]    bitver_q, bitver_d;
    logic [CNT_W-1:0]   instr_q, instr_d;

    logic is_load, is_store, is_beqz, is_jump, is_jreg, is_halt;
    logic mem_req_c, mem_escrita_c, end_sel_c, carrega_ir_c, escreve_pc_c, hab_escrita_c, parado_c;
    logic [1:0] fonte_pc_c;
    logic conta_c;

    // Instruction class decode of the latched fields; everything not listed below is ALU class
    always_comb begin
        is_load  = (opcode_q == 3'b000);
        is_store = (opcode_q == 3'b101);
        is_beqz  = (opcode_q == 3'b110);
        is_jump  = (opcode_q == 3'b100) && (bitver_q != 2'b01);
        is_halt  = (opcode_q == 3'b111) && (bitver_q == 2'b00);
        is_jreg  = (opcode_q == 3'b111) && (bitver_q == 2'b11);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado_q <= BUSCA;
            opcode_q <= '0;
            bitver_q <= '0;
            instr_q  <= '0;
        end else begin
            estado_q <= estado_d;
            opcode_q <= opcode_d;
            bitver_q <= bitver_d;
            instr_q  <= instr_d;
        end
    end

    always_comb begin
        estado_d      = estado_q;
        opcode_d      = opcode_q;
        bitver_d      = bitver_q;
        mem_req_c     = 1'b0;
        mem_escrita_c = 1'b0;
        end_sel_c     = 1'b0;
        carrega_ir_c  = 1'b0;
        escreve_pc_c  = 1'b0;
        fonte_pc_c    = PC_MAIS1;
        hab_escrita_c = 1'b0;
        parado_c      = 1'b0;
        conta_c       = 1'b0;

        case (estado_q)
            BUSCA: begin
                mem_req_c = 1'b1;
                if (MemPronto) begin
                    carrega_ir_c = 1'b1;
                    opcode_d     = OPcode;
                    bitver_d     = BitVerificao;
                    estado_d     = DECODIFICA;
                end
            end
            DECODIFICA: begin
                if (is_halt) begin
                    conta_c  = 1'b1;
                    estado_d = PARADO;
                end else begin
                    estado_d = EXECUTA;
                end
            end
            EXECUTA: begin
                if (is_jump) begin
                    escreve_pc_c = 1'b1;
                    fonte_pc_c   = PC_SALTO;
                    estado_d     = BUSCA;
                end else if (is_jreg) begin
                    escreve_pc_c = 1'b1;
                    fonte_pc_c   = PC_REG;
                    estado_d     = BUSCA;
                end else if (is_beqz) begin
                    escreve_pc_c = 1'b1;
                    fonte_pc_c   = Zero ? PC_DESVIO : PC_MAIS1;
                    estado_d     = BUSCA;
                end else if (is_load || is_store) begin
                    estado_d = MEMORIA;
                end else begin
                    estado_d = ESCRITA;
                end
            end
            MEMORIA: begin
                mem_req_c     = 1'b1;
                end_sel_c     = 1'b1;
                mem_escrita_c = is_store;
                if (MemPronto) begin
                    if (is_store) begin
                        escreve_pc_c = 1'b1;
                        estado_d     = BUSCA;
                    end else begin
                        estado_d = ESCRITA;
                    end
                end
            end
            ESCRITA: begin
                hab_escrita_c = 1'b1;
                escreve_pc_c  = 1'b1;
                estado_d      = BUSCA;
            end
            PARADO: begin
                parado_c = 1'b1;
            end
            default: begin
                estado_d = BUSCA;
            end
        endcase

        if (escreve_pc_c) begin
            conta_c = 1'b1;
        end
        instr_d = instr_q + CNT_W'(conta_c);
    end

    // Outputs are forced low while reset is held, even before the first edge
    always_comb begin
        MemReq        = reset_n & mem_req_c;
        MemEscrita    = reset_n & mem_escrita_c;
        EndSel        = reset_n & end_sel_c;
        CarregaIR     = reset_n & carrega_ir_c;
        EscrevePC     = reset_n & escreve_pc_c;
        FontePC       = reset_n ? fonte_pc_c : 2'b00;
        HabEscritaReg = reset_n & hab_escrita_c;
        Parado        = reset_n & parado_c;
        Estado        = reset_n ? 3'(estado_q) : 3'b000;
        Instrucoes    = reset_n ? instr_q : '0;
    end

endmodule

// File: tb/tb_sequenciador_ciclo.sv
// Directed bench for sequenciador_ciclo: per-cycle output vectors against hand-computed values.
module tb_sequenciador_ciclo;

    logic       clock;
    logic       reset_n;
    logic [2:0] OPcode;
    logic [1:0] BitVerificao;
    logic       Zero;
    logic       MemPronto;
    logic       MemReq, MemEscrita, EndSel, CarregaIR, EscrevePC, HabEscritaReg, Parado;
    logic [1:0] FontePC;
    logic [2:0] Estado;
    logic [7:0] Instrucoes;

    int n_checks = 0;
    int n_fail   = 0;

    sequenciador_ciclo dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .OPcode        (OPcode),
        .BitVerificao  (BitVerificao),
        .Zero          (Zero),
        .MemPronto     (MemPronto),
        .MemReq        (MemReq),
        .MemEscrita    (MemEscrita),
        .EndSel        (EndSel),
        .CarregaIR     (CarregaIR),
        .EscrevePC     (EscrevePC),
        .FontePC       (FontePC),
        .HabEscritaReg (HabEscritaReg),
        .Estado        (Estado),
        .Parado        (Parado),
        .Instrucoes    (Instrucoes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {Estado, MemReq, MemEscrita, EndSel, CarregaIR, EscrevePC, FontePC, HabEscritaReg, Parado}
    function automatic int vec(input int est, input int mr, input int me, input int es, input int cir,
                               input int epc, input int fpc, input int hab, input int par);
        return (est << 9) | (mr << 8) | (me << 7) | (es << 6) | (cir << 5) | (epc << 4) |
               (fpc << 2) | (hab << 1) | par;
    endfunction

    function automatic int obs_vec();
        return int'({Estado, MemReq, MemEscrita, EndSel, CarregaIR, EscrevePC, FontePC, HabEscritaReg, Parado});
    endfunction

    task automatic edge_step();
        @(posedge clock);
        #1;
    endtask

    // Check the current cycle's outputs, then advance one clock
    task automatic chk_cycle(input string tag, input int e);
        #1;
        check(tag, obs_vec(), e);
        edge_step();
    endtask

    task automatic fetch(input logic [2:0] op, input logic [1:0] bv);
        OPcode = op; BitVerificao = bv; MemPronto = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; OPcode = 3'b000; BitVerificao = 2'b00; Zero = 1'b0; MemPronto = 1'b1;
        edge_step();
        edge_step();
        check("reset_outputs", obs_vec(), 0);
        check("reset_count", int'(Instrucoes), 0);
        reset_n = 1'b1;

        // Add with zero-wait memory: 000,001,010,100
        fetch(3'b010, 2'b00);
        chk_cycle("add_busca",   vec(0,1,0,0,1,0,0,0,0));
        chk_cycle("add_decod",   vec(1,0,0,0,0,0,0,0,0));
        chk_cycle("add_exec",    vec(2,0,0,0,0,0,0,0,0));
        chk_cycle("add_escrita", vec(4,0,0,0,0,1,0,1,0));
        check("add_count", int'(Instrucoes), 1);

        // Load with two wait cycles in MEMORIA
        fetch(3'b000, 2'b00);
        chk_cycle("ld_busca", vec(0,1,0,0,1,0,0,0,0));
        chk_cycle("ld_decod", vec(1,0,0,0,0,0,0,0,0));
        MemPronto = 1'b0;
        chk_cycle("ld_exec",  vec(2,0,0,0,0,0,0,0,0));
        chk_cycle("ld_mem_w1", vec(3,1,0,1,0,0,0,0,0));
        chk_cycle("ld_mem_w2", vec(3,1,0,1,0,0,0,0,0));
        MemPronto = 1'b1;
        chk_cycle("ld_mem_ok", vec(3,1,0,1,0,0,0,0,0));
        chk_cycle("ld_escrita", vec(4,0,0,0,0,1,0,1,0));
        check("ld_count", int'(Instrucoes), 2);

        // Beqz taken, Zero toggled outside EXECUTA must not matter
        fetch(3'b110, 2'b00);
        Zero = 1'b0;
        chk_cycle("bz1_busca", vec(0,1,0,0,1,0,0,0,0));
        chk_cycle("bz1_decod", vec(1,0,0,0,0,0,0,0,0));
        Zero = 1'b1;
        chk_cycle("bz1_exec",  vec(2,0,0,0,0,1,1,0,0));
        check("bz1_count", int'(Instrucoes), 3);

        // Beqz not taken
        fetch(3'b110, 2'b00);
        chk_cycle("bz0_busca", vec(0,1,0,0,1,0,0,0,0));
        Zero = 1'b0;
        chk_cycle("bz0_decod", vec(1,0,0,0,0,0,0,0,0));
        chk_cycle("bz0_exec",  vec(2,0,0,0,0,1,0,0,0));
        check("bz0_count", int'(Instrucoes), 4);

        // Setz (100/01) follows the ALU path
        fetch(3'b100, 2'b01);
        chk_cycle("setz_busca",   vec(0,1,0,0,1,0,0,0,0));
        chk_cycle("setz_decod",   vec(1,0,0,0,0,0,0,0,0));
        chk_cycle("setz_exec",    vec(2,0,0,0,0,0,0,0,0));
        chk_cycle("setz_escrita", vec(4,0,0,0,0,1,0,1,0));
        check("setz_count", int'(Instrucoes), 5);

        // Jump (100/10)
        fetch(3'b100, 2'b10);
        chk_cycle("jmp_busca", vec(0,1,0,0,1,0,0,0,0));
        chk_cycle("jmp_decod", vec(1,0,0,0,0,0,0,0,0));
        chk_cycle("jmp_exec",  vec(2,0,0,0,0,1,2,0,0));
        check("jmp_count", int'(Instrucoes), 6);

        // JumpReg (111/11)
        fetch(3'b111, 2'b11);
        chk_cycle("jr_busca", vec(0,1,0,0,1,0,0,0,0));
        chk_cycle("jr_decod", vec(1,0,0,0,0,0,0,0,0));
        chk_cycle("jr_exec",  vec(2,0,0,0,0,1,3,0,0));
        check("jr_count", int'(Instrucoes), 7);

        // Store with one fetch wait cycle
        fetch(3'b101, 2'b00);
        MemPronto = 1'b0;
        chk_cycle("st_busca_w", vec(0,1,0,0,0,0,0,0,0));
        MemPronto = 1'b1;
        chk_cycle("st_busca",   vec(0,1,0,0,1,0,0,0,0));
        chk_cycle("st_decod",   vec(1,0,0,0,0,0,0,0,0));
        chk_cycle("st_exec",    vec(2,0,0,0,0,0,0,0,0));
        chk_cycle("st_mem",     vec(3,1,1,1,0,1,0,0,0));
        check("st_count", int'(Instrucoes), 8);

        // Reset during a MEMORIA wait: outputs drop at once, BUSCA after the edge
        fetch(3'b000, 2'b00);
        chk_cycle("rst_busca", vec(0,1,0,0,1,0,0,0,0));
        chk_cycle("rst_decod", vec(1,0,0,0,0,0,0,0,0));
        MemPronto = 1'b0;
        chk_cycle("rst_exec",  vec(2,0,0,0,0,0,0,0,0));
        #1;
        check("rst_mem_wait", obs_vec(), vec(3,1,0,1,0,0,0,0,0));
        reset_n = 1'b0;
        #1;
        check("rst_mem_forced", obs_vec(), 0);
        check("rst_mem_count_forced", int'(Instrucoes), 0);
        edge_step();
        reset_n = 1'b1;
        #1;
        check("rst_after_state", obs_vec(), vec(0,1,0,0,0,0,0,0,0));
        check("rst_after_count", int'(Instrucoes), 0);

        // 256 Jumps wrap the counter
        fetch(3'b100, 2'b00);
        for (int i = 0; i < 255; i++) begin
            edge_step();
            edge_step();
            edge_step();
        end
        check("wrap_255", int'(Instrucoes), 255);
        chk_cycle("wrap_busca", vec(0,1,0,0,1,0,0,0,0));
        chk_cycle("wrap_decod", vec(1,0,0,0,0,0,0,0,0));
        chk_cycle("wrap_exec",  vec(2,0,0,0,0,1,2,0,0));
        check("wrap_0", int'(Instrucoes), 0);

        // Halt: PARADO after two cycles, absorbing
        fetch(3'b111, 2'b00);
        chk_cycle("halt_busca", vec(0,1,0,0,1,0,0,0,0));
        chk_cycle("halt_decod", vec(1,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 20; i++) begin
            MemPronto = 1'(i % 2);
            Zero      = 1'(i % 3 == 0);
            chk_cycle("halt_parado", vec(5,0,0,0,0,0,0,0,1));
        end
        check("halt_count", int'(Instrucoes), 1);
        reset_n = 1'b0;
        edge_step();
        reset_n = 1'b1;
        MemPronto = 1'b0;
        #1;
        check("halt_reset_state", obs_vec(), vec(0,1,0,0,0,0,0,0,0));
        check("halt_reset_count", int'(Instrucoes), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequenciador_ciclo.md
# sequenciador_ciclo

Multi-cycle instruction sequencer for the 8-bit processor. It sits between instruction/data memory and the datapath control decoder. It steps each instruction through fetch, decode, execute, memory and write-back states, and generates the per-cycle enables: IR load, PC write and source, memory request and direction, register write. It also waits on a ready handshake for every memory access and holds the core in a halt state after Halt.

## Interface
- No parameters; all widths fixed by the 8-bit ISA (3-bit opcode, 2-bit verification field).
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- OPcode  in  3  opcode from memory read bus, valid while MemPronto=1 in BUSCA
- BitVerificao  in  2  verification bits from memory read bus, same timing as OPcode
- Zero  in  1  ALU zero flag, sampled in EXECUTA
- MemPronto  in  1  memory ready; completes the current access
- MemReq  out  1  memory access request
- MemEscrita  out  1  1=write, 0=read; valid only with MemReq
- EndSel  out  1  address mux: 0=PC, 1=ALU result
- CarregaIR  out  1  load instruction register
- EscrevePC  out  1  PC write enable
- FontePC  out  2  00=PC+1, 01=branch target, 10=jump immediate, 11=register (JumpReg)
- HabEscritaReg  out  1  register file write enable
- Estado  out  3  current state code
- Parado  out  1  core halted
- Instrucoes  out  8  retired-instruction counter

## Operation
- States and codes: BUSCA 000, DECODIFICA 001, EXECUTA 010, MEMORIA 011, ESCRITA 100, PARADO 101. Codes 110/111 are illegal and go to BUSCA on the next edge.
- **BUSCA**
  - Outputs: MemReq=1, MemEscrita=0, EndSel=0.
  - On MemPronto=1: CarregaIR=1, OPcode/BitVerificao latched internally, go to DECODIFICA.
  - Otherwise stay in BUSCA.
- **Decode of the latched fields** into classes:
  - 000 Load
  - 001 SLT, 010 Add, 011 AddI: class ULA
  - 100 with BitVerificao=01: Setz (class ULA)
  - 100 with any other BitVerificao: Jump
  - 101 Store
  - 110 Beqz
  - 111: BitVerificao 00=Halt, 01=InveSin (ULA), 10=InvTudo (ULA), 11=JumpReg
- **DECODIFICA** (1 cycle)
  - Halt: go to PARADO.
  - Otherwise: go to EXECUTA.
- **EXECUTA** (1 cycle)
  - Jump: EscrevePC=1, FontePC=10, go to BUSCA.
  - JumpReg: EscrevePC=1, FontePC=11, go to BUSCA.
  - Beqz: EscrevePC=1; FontePC=01 if Zero=1, else 00; go to BUSCA.
  - Load/Store: go to MEMORIA.
  - ULA class: go to ESCRITA.
- **MEMORIA**
  - Outputs: MemReq=1, EndSel=1; MemEscrita=1 for Store, 0 for Load.
  - Waits for MemPronto.
  - On MemPronto with Store: EscrevePC=1, FontePC=00, go to BUSCA.
  - On MemPronto with Load: go to ESCRITA.
- **ESCRITA** (1 cycle): HabEscritaReg=1, EscrevePC=1, FontePC=00, go to BUSCA.
- **PARADO**: absorbing; Parado=1, every enable 0. Left only by reset.
- Output generation:
  - All outputs are combinational from registered state and latched fields, except CarregaIR and the MEMORIA EscrevePC, which are also qualified by MemPronto.
  - Every output not listed for a state is 0.
  - FontePC is 00 when EscrevePC=0.
- Instrucoes:
  - Increments by 1 on every edge where EscrevePC=1, and on the DECODIFICA→PARADO transition.
  - 8-bit, wraps 255→0.
  - Exactly one increment per instruction.

## Timing
- Reset:
  - reset_n=0 at an edge forces state BUSCA, Instrucoes=0 and clears the latched fields to Load/00. This applies from any state, including mid-memory access and PARADO.
  - While reset_n=0, all outputs are forced to 0, including MemReq; Estado reads 000.
- Minimum latency with zero-wait memory (MemPronto high in the request cycle):
  - Jump/JumpReg/Beqz: 3 cycles.
  - ULA class: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Halt: 2 cycles to PARADO.
- Each wait cycle on MemPronto adds exactly 1 cycle.
- During a wait, MemReq, MemEscrita and EndSel hold stable until the MemPronto cycle inclusive.
- MemPronto outside BUSCA/MEMORIA is ignored.
- Zero is sampled only in EXECUTA of Beqz; changes elsewhere have no effect.

## Test plan
- Reset, then Add (010) with MemPronto tied 1 -> Estado 000,001,010,100,000. HabEscritaReg and EscrevePC high only in the ESCRITA cycle, FontePC=00. Instrucoes=1.
- Load (000) with MemPronto low for 2 cycles in MEMORIA -> MemReq=1, EndSel=1, MemEscrita=0 held for 3 cycles. Total 7 cycles. One register write.
- Beqz (110) twice, Zero=1 then Zero=0 -> EXECUTA shows FontePC=01 then 00, each with EscrevePC=1. 3 cycles each.
- OPcode 100 with BitVerificao 01 vs 10 -> Setz takes the ULA path (4 cycles, register write). Jump takes 3 cycles with FontePC=10. OPcode 111/11 -> FontePC=11.
- OPcode 111/00 -> PARADO after 2 cycles, Parado=1. MemReq=0 for 20 further cycles. Instrucoes increments once. reset_n=0 -> BUSCA, Instrucoes=0.
- Run 256 single-cycle-memory Jumps -> Instrucoes wraps to 0. Also: reset asserted during a MEMORIA wait -> MemReq=0 in the same cycle, BUSCA next edge.
